// File: rtl/scan_capture.sv
// Receive side of the 7-segment scan bus: checks descending scan order and rebuilds a frame-coherent digit image.
// Optional SCAN_CAPTURE_ERRCNT_EN adds a saturating 8-bit err_count output.
module scan_capture #(
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                        clk_1ms,
  input  logic                        reset,
  input  logic                        scan_valid,
  input  logic [2:0]                  digit_select,
  input  logic [SEG_W-1:0]            segments,
  output logic [NUM_DIGITS*SEG_W-1:0] digits_out,
  output logic                        frame_done,
  output logic                        scan_err,
  output logic                        locked
`ifdef SCAN_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]                  err_count
`endif
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [CODE_W-1:0] TOP_CODE  = CODE_W'(NUM_DIGITS - 1);
  localparam logic [CODE_W-1:0] NEXT_CODE = CODE_W'(NUM_DIGITS - 2);
  localparam logic [CNT_W-1:0]  LOCK_CNT  = CNT_W'(LOCK_FRAMES);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t                        state_q, state_n;
  logic [CODE_W-1:0]             expected_q, expected_n;
  logic [CODE_W-1:0]             last_q, last_n;
  logic [SEG_W-1:0]              shadow_q [NUM_DIGITS];
  logic [SEG_W-1:0]              shadow_n [NUM_DIGITS];
  logic [CNT_W-1:0]              good_q, good_n;
  logic [NUM_DIGITS*SEG_W-1:0]   digits_n;
  logic                          frame_done_n, scan_err_n, locked_n;
`ifdef SCAN_CAPTURE_ERRCNT_EN
  logic [7:0]                    err_count_n;
`endif

  // State and output registers
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= TOP_CODE;
      last_q     <= '0;
      shadow_q   <= '{default: '1};
      good_q     <= '0;
      digits_out <= '1;
      frame_done <= 1'b0;
      scan_err   <= 1'b0;
      locked     <= 1'b0;
`ifdef SCAN_CAPTURE_ERRCNT_EN
      err_count  <= '0;
`endif
    end else begin
      state_q    <= state_n;
      expected_q <= expected_n;
      last_q     <= last_n;
      shadow_q   <= shadow_n;
      good_q     <= good_n;
      digits_out <= digits_n;
      frame_done <= frame_done_n;
      scan_err   <= scan_err_n;
      locked     <= locked_n;
`ifdef SCAN_CAPTURE_ERRCNT_EN
      err_count  <= err_count_n;
`endif
    end
  end

  // Scan-order tracking, shadow capture and frame publication
  always_comb begin
    state_n      = state_q;
    expected_n   = expected_q;
    last_n       = last_q;
    shadow_n     = shadow_q;
    good_n       = good_q;
    digits_n     = digits_out;
    frame_done_n = 1'b0;
    scan_err_n   = 1'b0;
    locked_n     = locked;

    if (scan_valid) begin
      case (state_q)
        HUNT: begin
          if (digit_select == TOP_CODE) begin
            shadow_n[TOP_CODE] = segments;
            last_n             = TOP_CODE;
            expected_n         = NEXT_CODE;
            state_n            = TRACK;
          end
        end
        TRACK: begin
          if (digit_select == expected_q) begin
            shadow_n[digit_select] = segments;
            last_n                 = digit_select;
            if (digit_select == '0) begin
              // Publish the whole frame including the slot written this edge
              for (int k = 0; k < NUM_DIGITS; k++) begin
                digits_n[k*SEG_W +: SEG_W] = shadow_n[k];
              end
              frame_done_n = 1'b1;
              if (good_q != LOCK_CNT) good_n = good_q + CNT_W'(1);
              if (good_n == LOCK_CNT) locked_n = 1'b1;
              expected_n = TOP_CODE;
            end else begin
              expected_n = expected_q - CODE_W'(1);
            end
          end else if (digit_select == last_q) begin
            shadow_n[digit_select] = segments;
          end else begin
            scan_err_n = 1'b1;
            good_n     = '0;
            locked_n   = 1'b0;
            if (digit_select == TOP_CODE) begin
              shadow_n[TOP_CODE] = segments;
              last_n             = TOP_CODE;
              expected_n         = NEXT_CODE;
            end else begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

`ifdef SCAN_CAPTURE_ERRCNT_EN
  // Saturating error counter, cleared only by reset
  always_comb begin
    err_count_n = err_count;
    if (scan_err_n && (err_count != 8'hFF)) err_count_n = err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_scan_capture.sv
// Table-driven bench for scan_capture with a frame-image scoreboard.
// Build with SCAN_CAPTURE_ERRCNT_EN defined to also check err_count.
module tb_scan_capture;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned IMG_W      = NUM_DIGITS * SEG_W;
  localparam logic [IMG_W-1:0] BLANK = '1;

  logic             clk_1ms = 1'b0;
  logic             reset;
  logic             scan_valid;
  logic [2:0]       digit_select;
  logic [SEG_W-1:0] segments;
  logic [IMG_W-1:0] digits_out;
  logic             frame_done, scan_err, locked;
`ifdef SCAN_CAPTURE_ERRCNT_EN
  logic [7:0]       err_count;
`endif

  scan_capture #(.NUM_DIGITS(NUM_DIGITS), .SEG_W(SEG_W), .LOCK_FRAMES(2)) dut (
    .clk_1ms      (clk_1ms),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .digit_select (digit_select),
    .segments     (segments),
    .digits_out   (digits_out),
    .frame_done   (frame_done),
    .scan_err     (scan_err),
    .locked       (locked)
`ifdef SCAN_CAPTURE_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk_1ms = ~clk_1ms;

  typedef struct {
    logic             v;
    logic [2:0]       code;
    logic [SEG_W-1:0] seg;
    logic             fd;
    logic             err;
    logic             lk;
    logic [IMG_W-1:0] img;
  } vec_t;

  vec_t             vecs[$];
  logic [IMG_W-1:0] sb_q[$];
  logic [IMG_W-1:0] cur_img;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               exp_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic [7:0] s,
                     input logic fd, input logic err, input logic lk, input logic [IMG_W-1:0] img);
    vec_t t;
    t.v = v; t.code = c; t.seg = s; t.fd = fd; t.err = err; t.lk = lk; t.img = img;
    vecs.push_back(t);
  endtask

  // Drive one sample, clock it, and check the registered response
  task automatic step(input string tag, input logic v, input logic [2:0] c, input logic [7:0] s,
                      input logic fd, input logic err, input logic lk, input logic [IMG_W-1:0] img);
    logic [IMG_W-1:0] e;
    scan_valid = v; digit_select = c; segments = s;
    if (fd) sb_q.push_back(img);
    if (err) exp_errs++;
    @(posedge clk_1ms);
    #1;
    check({tag, " frame_done"}, 64'(frame_done), 64'(fd));
    check({tag, " scan_err"},   64'(scan_err),   64'(err));
    check({tag, " locked"},     64'(locked),     64'(lk));
`ifdef SCAN_CAPTURE_ERRCNT_EN
    check({tag, " err_count"},  64'(err_count),  64'(exp_errs));
`endif
    if (frame_done) begin
      if (sb_q.size() == 0) begin
        check({tag, " unexpected frame"}, 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check({tag, " digits_out frame"}, 64'(digits_out), 64'(e));
        cur_img = e;
      end
    end else begin
      check({tag, " digits_out hold"}, 64'(digits_out), 64'(cur_img));
    end
  endtask

  initial begin
    localparam logic [IMG_W-1:0] IMG1 = 40'h92F9FFC0A4;
    localparam logic [IMG_W-1:0] IMG2 = 40'h1122334455;
    localparam logic [IMG_W-1:0] IMG3 = 40'h9282FFC0A4;
    localparam logic [IMG_W-1:0] IMG4 = 40'h0304050607;

    // Clean frames: unlocked after the first, locked after the second
    for (int f = 0; f < 2; f++) begin
      add(1, 3'd4, 8'h92, 0, 0, f == 1 ? 1'b0 : 1'b0, 0);
      add(1, 3'd3, 8'hF9, 0, 0, 0, 0);
      add(1, 3'd2, 8'hFF, 0, 0, 0, 0);
      add(1, 3'd1, 8'hC0, 0, 0, 0, 0);
      add(1, 3'd0, 8'hA4, 1, 0, f == 1, IMG1);
    end
    // Order violation 4,3,1 drops lock
    add(1, 3'd4, 8'h92, 0, 0, 1, 0);
    add(1, 3'd3, 8'hF9, 0, 0, 1, 0);
    add(1, 3'd1, 8'hC0, 0, 1, 0, 0);
    // Mid-frame start ignored in HUNT, then a full frame
    add(1, 3'd2, 8'hAA, 0, 0, 0, 0);
    add(1, 3'd1, 8'hAA, 0, 0, 0, 0);
    add(1, 3'd0, 8'hAA, 0, 0, 0, 0);
    add(1, 3'd4, 8'h11, 0, 0, 0, 0);
    add(1, 3'd3, 8'h22, 0, 0, 0, 0);
    add(1, 3'd2, 8'h33, 0, 0, 0, 0);
    add(1, 3'd1, 8'h44, 0, 0, 0, 0);
    add(1, 3'd0, 8'h55, 1, 0, 0, IMG2);
    // Repeat of 0, held digit 3, valid gap inside the frame
    add(1, 3'd0, 8'h66, 0, 0, 0, 0);
    add(1, 3'd4, 8'h92, 0, 0, 0, 0);
    add(1, 3'd3, 8'hF9, 0, 0, 0, 0);
    add(1, 3'd3, 8'h82, 0, 0, 0, 0);
    add(1, 3'd2, 8'hFF, 0, 0, 0, 0);
    add(0, 3'd6, 8'h00, 0, 0, 0, 0);
    add(0, 3'd1, 8'h00, 0, 0, 0, 0);
    add(1, 3'd1, 8'hC0, 0, 0, 0, 0);
    add(1, 3'd0, 8'hA4, 1, 0, 1, IMG3);
    // Out-of-range code in TRACK
    add(1, 3'd6, 8'h00, 0, 1, 0, 0);
    // Frame-start code out of order resynchronises immediately
    add(1, 3'd4, 8'h01, 0, 0, 0, 0);
    add(1, 3'd3, 8'h02, 0, 0, 0, 0);
    add(1, 3'd4, 8'h03, 0, 1, 0, 0);
    add(1, 3'd3, 8'h04, 0, 0, 0, 0);
    add(1, 3'd2, 8'h05, 0, 0, 0, 0);
    add(1, 3'd1, 8'h06, 0, 0, 0, 0);
    add(1, 3'd0, 8'h07, 1, 0, 0, IMG4);

    reset = 1'b1; scan_valid = 1'b0; digit_select = '0; segments = '0;
    cur_img = BLANK;
    repeat (2) @(posedge clk_1ms);
    #1;
    check("reset digits_out", 64'(digits_out), 64'(BLANK));
    check("reset frame_done", 64'(frame_done), 64'(0));
    check("reset scan_err",   64'(scan_err),   64'(0));
    check("reset locked",     64'(locked),     64'(0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].seg,
           vecs[i].fd, vecs[i].err, vecs[i].lk, vecs[i].img);
    end

    // Reset mid-frame discards the partial shadow and the published image
    step("rst_a", 1, 3'd4, 8'h00, 0, 0, 0, 0);
    step("rst_b", 1, 3'd3, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    cur_img = BLANK;
    exp_errs = 0;
    check("async reset digits_out", 64'(digits_out), 64'(BLANK));
    check("async reset frame_done", 64'(frame_done), 64'(0));
    check("async reset locked",     64'(locked),     64'(0));
    #1;
    reset = 1'b0;
    step("post_rst2", 1, 3'd2, 8'h00, 0, 0, 0, 0);
    step("post_rst1", 1, 3'd1, 8'h00, 0, 0, 0, 0);
    step("post_rst0", 1, 3'd0, 8'h00, 0, 0, 0, 0);

    check("scoreboard drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
